// File: rtl/gs_div_pkg.sv
// Shared types, constants and fixed-point helpers for the Goldschmidt divider.
// Operands arrive as Q1.15; all internal values and the result are Q2.30.
package gs_div_pkg;

    localparam int unsigned W_IN       = 16;
    localparam int unsigned W_INT      = 32;
    localparam int unsigned W_PROD     = 2 * W_INT;
    localparam int unsigned FRAC       = 30;
    localparam int unsigned PAD        = W_INT - W_IN - 1;
    localparam int unsigned IDX_BITS   = 4;
    localparam int unsigned IA_BITS    = 8;
    localparam int unsigned SEED_SHIFT = FRAC - (IA_BITS - 1);
    localparam int unsigned CNT_BITS   = 3;

    localparam logic [W_INT-1:0] TWO_Q230 = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        ITER,
        DONE
    } state_t;

    // Q1.7 reciprocal of each mantissa bin midpoint: floor(4096 / (33 + 2i)).
    localparam logic [IA_BITS-1:0] SEED_ROM [0:(2**IDX_BITS)-1] = '{
        8'd124, 8'd117, 8'd110, 8'd105,
        8'd99,  8'd95,  8'd91,  8'd87,
        8'd83,  8'd80,  8'd77,  8'd74,
        8'd71,  8'd69,  8'd67,  8'd65
    };

    // Q2.30 x Q2.30 multiply keeping product bits [61:30].
    function automatic logic [W_INT-1:0] mul_trunc(input logic [W_INT-1:0] a,
                                                   input logic [W_INT-1:0] b);
        logic [W_PROD-1:0] p;
        p = W_PROD'(a) * W_PROD'(b);
        return W_INT'(p >> FRAC);
    endfunction

endpackage

// File: rtl/gs_seed_rom.sv
// Reciprocal seed lookup: divisor mantissa bits D[14:11] to a Q1.7 initial approximation.
module gs_seed_rom
    import gs_div_pkg::*;
(
    input  logic [IDX_BITS-1:0] idx,
    output logic [IA_BITS-1:0]  ia_c
);

    assign ia_c = SEED_ROM[idx];

endmodule

// File: rtl/gs_div_unit.sv
// Goldschmidt divider: accepts N/D (Q1.15), seeds 1/D from a ROM, refines ITERS times,
// and returns N/D as Q2.30 over a valid/ready handshake, one operation in flight.
module gs_div_unit
    import gs_div_pkg::*;
#(
    parameter int unsigned ITERS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  N,
    input  logic [W_IN-1:0]  D,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_INT-1:0] result,
    output logic             err
);

    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(ITERS - 1);

    state_t              state, state_nx;
    logic [W_INT-1:0]    nr, nr_nx;
    logic [W_INT-1:0]    dr, dr_nx;
    logic [CNT_BITS-1:0] cnt, cnt_nx;
    logic [W_INT-1:0]    result_nx;
    logic                err_nx;
    logic                out_valid_nx;
    logic                in_ready_nx;

    logic [IA_BITS-1:0]  ia_c;
    logic [W_INT-1:0]    k_c;
    logic [W_INT-1:0]    nr_prod_c;
    logic [W_INT-1:0]    dr_prod_c;

    // Dr holds D at bits [30:15], so D[14:11] sits at Dr[29:26].
    gs_seed_rom u_seed_rom (
        .idx  (dr[29:26]),
        .ia_c (ia_c)
    );

    // Shared multiplier pair: K is the ROM seed in SEED and (2 - Dr) in ITER.
    always_comb begin
        k_c       = TWO_Q230 - dr;
        if (state == SEED) begin
            k_c = W_INT'(ia_c) << SEED_SHIFT;
        end
        nr_prod_c = mul_trunc(nr, k_c);
        dr_prod_c = mul_trunc(dr, k_c);
    end

    always_comb begin
        state_nx  = state;
        nr_nx     = nr;
        dr_nx     = dr;
        cnt_nx    = cnt;
        result_nx = result;
        err_nx    = err;

        unique case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    nr_nx    = {1'b0, N, {PAD{1'b0}}};
                    dr_nx    = {1'b0, D, {PAD{1'b0}}};
                    state_nx = SEED;
                end
            end
            SEED: begin
                // An unnormalized divisor (including zero) cannot converge; report it instead.
                if (!dr[FRAC]) begin
                    err_nx    = 1'b1;
                    result_nx = '0;
                    state_nx  = DONE;
                end else begin
                    nr_nx    = nr_prod_c;
                    dr_nx    = dr_prod_c;
                    cnt_nx   = '0;
                    state_nx = ITER;
                end
            end
            ITER: begin
                nr_nx  = nr_prod_c;
                dr_nx  = dr_prod_c;
                cnt_nx = cnt + CNT_BITS'(1);
                if (cnt == LAST_CNT) begin
                    result_nx = nr_prod_c;
                    err_nx    = 1'b0;
                    state_nx  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        out_valid_nx = (state_nx == DONE);
        in_ready_nx  = (state_nx == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            nr        <= '0;
            dr        <= '0;
            cnt       <= '0;
            result    <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_nx;
            nr        <= nr_nx;
            dr        <= dr_nx;
            cnt       <= cnt_nx;
            result    <= result_nx;
            err       <= err_nx;
            out_valid <= out_valid_nx;
            in_ready  <= in_ready_nx;
        end
    end

endmodule

// File: tb/tb_gs_div_unit.sv
// Self-checking bench for gs_div_unit: directed boundary scenarios plus randomized
// operands compared against an arithmetic reference of the Goldschmidt recurrence.
module tb_gs_div_unit;

    localparam int ITERS = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] n_in = '0;
    logic [15:0] d_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    gs_div_unit #(.ITERS(ITERS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .N         (n_in),
        .D         (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Reference: real-valued recurrence on integers scaled by 2^30, truncated each step.
    function automatic void model_div(input logic [15:0] n, input logic [15:0] d,
                                      output logic [31:0] r, output logic e, output int lat);
        longint unsigned nr, dr, k, seed, tn, td;
        if (d[15] == 1'b0) begin
            r = '0; e = 1'b1; lat = 2;
            return;
        end
        seed = 64'(4096 / (33 + 2 * int'(d[14:11])));
        k  = seed * 64'd8388608;
        nr = 64'(n) * 64'd32768;
        dr = 64'(d) * 64'd32768;
        nr = ((nr * k) / 64'd1073741824) % 64'd4294967296;
        dr = ((dr * k) / 64'd1073741824) % 64'd4294967296;
        for (int i = 0; i < ITERS; i++) begin
            k  = 64'h8000_0000 - dr;
            tn = ((nr * k) / 64'd1073741824) % 64'd4294967296;
            td = ((dr * k) / 64'd1073741824) % 64'd4294967296;
            nr = tn;
            dr = td;
        end
        r = nr[31:0]; e = 1'b0; lat = ITERS + 2;
    endfunction

    task automatic do_op(input logic [15:0] n, input logic [15:0] d, input bit ack, input bit early,
                         output logic [31:0] r, output logic e, output int lat);
        int waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(posedge clk); #1; waitc++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end
        n_in = n; d_in = d; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (early) out_ready = 1'b1;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        r = result; e = err;
        if (ack) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, err} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags in_ready/out_valid/err=%b required 100", {in_ready, out_valid, err});
        end
        n_checks++;
        if (result !== 32'h0) begin
            n_fail++; $display("FAIL reset_result got %h required 00000000", result);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_unity();
        logic [31:0] r, mr; logic e, me; int lat, mlat;
        model_div(16'h8000, 16'h8000, mr, me, mlat);
        do_op(16'h8000, 16'h8000, 1'b1, 1'b0, r, e, lat);
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL unity_latency got %0d required 5", lat); end
        n_checks++;
        if (!(r >= 32'h3FFF_FFFE && r <= 32'h4000_0000)) begin
            n_fail++; $display("FAIL unity_range got %h required 3ffffffe..40000000", r);
        end
        n_checks++;
        if (r !== mr || e !== 1'b0) begin
            n_fail++; $display("FAIL unity_exact got %h/%b required %h/0", r, e, mr);
        end
    endtask

    task automatic test_ratio();
        logic [31:0] r, mr; logic e, me; int lat, mlat;
        model_div(16'hC000, 16'h8000, mr, me, mlat);
        do_op(16'hC000, 16'h8000, 1'b1, 1'b0, r, e, lat);
        n_checks++;
        if (!(r >= 32'h5FFF_FFFE && r <= 32'h6000_0000)) begin
            n_fail++; $display("FAIL ratio_range got %h required 5ffffffe..60000000", r);
        end
        n_checks++;
        if (r !== mr || e !== 1'b0) begin
            n_fail++; $display("FAIL ratio_exact got %h/%b required %h/0", r, e, mr);
        end
    endtask

    task automatic test_dmax();
        logic [31:0] r, mr; logic e, me; int lat, mlat;
        longint diff;
        model_div(16'h8000, 16'hFFFF, mr, me, mlat);
        do_op(16'h8000, 16'hFFFF, 1'b1, 1'b0, r, e, lat);
        diff = longint'(r) - longint'(32'h2000_2000);
        n_checks++;
        if (diff > 4 || diff < -4) begin
            n_fail++; $display("FAIL dmax_range got %h required 20002000 +/-4", r);
        end
        n_checks++;
        if (r !== mr || e !== 1'b0 || lat !== 5) begin
            n_fail++; $display("FAIL dmax_exact got %h/%b/%0d required %h/0/5", r, e, lat, mr);
        end
    endtask

    task automatic test_errors();
        logic [15:0] dv [2];
        logic [31:0] r; logic e; int lat;
        dv[0] = 16'h4000; dv[1] = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            do_op(16'h8000, dv[i], 1'b1, 1'b0, r, e, lat);
            n_checks++;
            if (lat !== 2 || e !== 1'b1 || r !== 32'h0) begin
                n_fail++;
                $display("FAIL err_path D=%h got lat=%0d err=%b res=%h required lat=2 err=1 res=00000000",
                         dv[i], lat, e, r);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] r0, mr; logic e0, me; int lat, mlat;
        model_div(16'hA000, 16'h9000, mr, me, mlat);
        do_op(16'hA000, 16'h9000, 1'b0, 1'b0, r0, e0, lat);
        n_checks++;
        if (r0 !== mr || e0 !== me) begin
            n_fail++; $display("FAIL hold_value got %h/%b required %h/%b", r0, e0, mr, me);
        end
        for (int i = 0; i < 10; i++) begin
            if (i == 3 || i == 6) begin
                n_in = 16'hFFFF; d_in = 16'h8000; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            n_checks++;
            if ({out_valid, in_ready, err, result} !== {1'b1, 1'b0, me, mr}) begin
                n_fail++;
                $display("FAIL hold_stable cyc=%0d got v=%b rdy=%b err=%b res=%h required v=1 rdy=0 err=%b res=%h",
                         i, out_valid, in_ready, err, result, me, mr);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL hold_release v/rdy=%b required 01", {out_valid, in_ready});
        end
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL hold_no_accept v/rdy=%b required 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r, mr; logic e, me; int lat, mlat;
        n_in = 16'hC000; d_in = 16'h8000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, err, result} !== {1'b0, 1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_mid got v=%b rdy=%b err=%b res=%h required v=0 rdy=1 err=0 res=00000000",
                     out_valid, in_ready, err, result);
        end
        #3 reset = 1'b1;
        @(posedge clk); #1;
        model_div(16'hC000, 16'h8000, mr, me, mlat);
        do_op(16'hC000, 16'h8000, 1'b1, 1'b0, r, e, lat);
        n_checks++;
        if (r !== mr || e !== 1'b0 || lat !== 5) begin
            n_fail++; $display("FAIL reset_mid_fresh got %h/%b/%0d required %h/0/5", r, e, lat, mr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r, mr; logic e, me; int lat, mlat;
        model_div(16'h9234, 16'hB111, mr, me, mlat);
        do_op(16'h9234, 16'hB111, 1'b1, 1'b1, r, e, lat);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_bubble v/rdy=%b required 01", {out_valid, in_ready});
        end
        n_checks++;
        if (r !== mr || lat !== 5) begin
            n_fail++; $display("FAIL b2b_first got %h/%0d required %h/5", r, lat, mr);
        end
        model_div(16'h0F0F, 16'hE000, mr, me, mlat);
        do_op(16'h0F0F, 16'hE000, 1'b1, 1'b0, r, e, lat);
        n_checks++;
        if (r !== mr || e !== 1'b0 || lat !== 5) begin
            n_fail++; $display("FAIL b2b_second got %h/%b/%0d required %h/0/5", r, e, lat, mr);
        end
    endtask

    task automatic test_random();
        logic [15:0] n, d;
        logic [31:0] r, mr; logic e, me; int lat, mlat;
        bit early;
        for (int i = 0; i < 40; i++) begin
            n = 16'($urandom);
            d = 16'($urandom);
            if ($urandom_range(0, 7) != 0) d[15] = 1'b1;
            early = 1'($urandom_range(0, 1));
            model_div(n, d, mr, me, mlat);
            do_op(n, d, 1'b1, early, r, e, lat);
            n_checks++;
            if (r !== mr || e !== me) begin
                n_fail++;
                $display("FAIL rand_value N=%h D=%h got %h/%b required %h/%b", n, d, r, e, mr, me);
            end
            n_checks++;
            if (lat !== mlat) begin
                n_fail++; $display("FAIL rand_latency N=%h D=%h got %0d required %0d", n, d, lat, mlat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_ratio();
        test_dmax();
        test_errors();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
